// File: rtl/caxi4interconnect_ram_pkg.sv
// ============================================================================
// caxi4interconnect_ram_pkg : buffer-state encodings and pointer arithmetic
// shared by the RAM block reader and writer.  Rev 1.0
// ============================================================================
`default_nettype none

package caxi4interconnect_ram_pkg;

    typedef logic [1:0] buf_state_t;

    localparam buf_state_t BUF_EMPTY = 2'd0;
    localparam buf_state_t BUF_ONE   = 2'd1;
    localparam buf_state_t BUF_TWO   = 2'd2;

    localparam int PTR_CALC_W = 32;

    // Callers truncate the result to their own pointer width; the modulo
    // wrap of the difference is preserved by the low bits.
    function automatic logic [PTR_CALC_W-1:0] ptr_diff(
        input logic [PTR_CALC_W-1:0] wr_ptr,
        input logic [PTR_CALC_W-1:0] rd_ptr
    );
        return wr_ptr - rd_ptr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/caxi4interconnect_ram_rd_skid.sv
// ============================================================================
// caxi4interconnect_ram_rd_skid : 2-entry output/skid buffer with the
// valid/ready occupancy state machine.  Rev 1.0
// ============================================================================
`default_nettype none

module caxi4interconnect_ram_rd_skid
    import caxi4interconnect_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  fetch_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            cnt_o,
    output logic                  pop_o
);

    buf_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  load_out_ram;
    logic                  load_out_skid;
    logic                  load_skid;

    assign valid_o = (state_q != BUF_EMPTY);
    assign pop_o   = valid_o & ready_i;
    assign data_o  = out_q;
    assign cnt_o   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (fetch_i) state_d = BUF_ONE;
                BUF_ONE: begin
                    if (fetch_i && !pop_o)      state_d = BUF_TWO;
                    else if (!fetch_i && pop_o) state_d = BUF_EMPTY;
                end
                BUF_TWO:   if (pop_o && !fetch_i) state_d = BUF_ONE;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    // Data-path steering; the top only fetches in TWO when a pop frees a slot.
    always_comb begin
        load_out_ram  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (!flush_i) begin
            case (state_q)
                BUF_EMPTY: load_out_ram = fetch_i;
                BUF_ONE: begin
                    load_out_ram = fetch_i & pop_o;
                    load_skid    = fetch_i & ~pop_o;
                end
                BUF_TWO: begin
                    load_out_skid = pop_o;
                    load_skid     = pop_o & fetch_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_ram) begin
                out_q <= data_i;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= data_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/caxi4interconnect_ram_block_reader.sv
// ============================================================================
// caxi4interconnect_ram_block_reader : in-order read-side controller for the
// interconnect RAM buffers.  Optional macro: CAXI4_RAM_RD_PTR_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module caxi4interconnect_ram_block_reader
    import caxi4interconnect_ram_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sysReset,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  empty,
    output logic                  ptr_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] w_avail;
    logic [1:0]       w_cnt;
    logic             w_pop;
    logic             w_fetch;
    logic             w_fetch_block;

    if (MEM_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("MEM_DEPTH must equal 2**ADDR_WIDTH");
    end

    assign w_avail = PTR_W'(ptr_diff(PTR_CALC_W'(wr_ptr), PTR_CALC_W'(rd_ptr_q)));
    assign w_fetch = (w_avail != '0) & ((w_cnt != BUF_TWO) | w_pop)
                   & ~flush & ~w_fetch_block;

    assign rd_ptr  = rd_ptr_q;
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign empty   = (w_avail == '0) & (w_cnt == BUF_EMPTY);

    // Flush adopts the writer pointer sampled this cycle, so a same-cycle
    // write is discarded along with everything already queued.
    always_ff @(posedge clk or negedge sysReset) begin
        if (!sysReset) begin
            rd_ptr_q <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr;
        end else if (w_fetch) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

`ifdef CAXI4_RAM_RD_PTR_CHECK_EN
    logic ptr_err_q;
    logic w_illegal;

    assign w_illegal     = (w_avail > PTR_W'(MEM_DEPTH));
    assign w_fetch_block = ptr_err_q | w_illegal;
    assign ptr_err       = ptr_err_q;

    always_ff @(posedge clk or negedge sysReset) begin
        if (!sysReset) begin
            ptr_err_q <= 1'b0;
        end else if (w_illegal) begin
            ptr_err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (sysReset && w_illegal) begin
            $error("ram_block_reader: illegal pointers wr=%0d rd=%0d", wr_ptr, rd_ptr_q);
        end
    end
`endif
`else
    assign w_fetch_block = 1'b0;
    assign ptr_err       = 1'b0;
`endif

    caxi4interconnect_ram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (sysReset),
        .flush_i (flush),
        .fetch_i (w_fetch),
        .data_i  (ram_data),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data),
        .cnt_o   (w_cnt),
        .pop_o   (w_pop)
    );

endmodule

`default_nettype wire

// File: tb/tb_caxi4interconnect_ram_block_reader.sv
// ============================================================================
// tb_caxi4interconnect_ram_block_reader : directed self-checking bench for the
// RAM block reader.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_caxi4interconnect_ram_block_reader;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          sysReset;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_data;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          empty;
    logic          ptr_err;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign ram_data = mem[rd_addr];

    caxi4interconnect_ram_block_reader #(
        .MEM_DEPTH  (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .sysReset (sysReset),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .rd_addr  (rd_addr),
        .ram_data (ram_data),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .empty    (empty),
        .ptr_err  (ptr_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writer model: store entries at the write pointer and advance it.
    task automatic preload(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[AW-1:0]] = base + DW'(i);
            wr_ptr = wr_ptr + PW'(1);
        end
    endtask

    // Moves both pointers to target via flush without ever exceeding MEM_DEPTH apart.
    task automatic flush_to(input logic [PW-1:0] target);
        logic [PW-1:0] gap;
        flush = 1'b1;
        step();
        while (wr_ptr != target) begin
            gap = target - wr_ptr;
            if (gap > PW'(1000)) wr_ptr = wr_ptr + PW'(1000);
            else                 wr_ptr = target;
            step();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        sysReset = 1'b0;
        flush    = 1'b0;
        m_ready  = 1'b0;
        wr_ptr   = '0;
        repeat (3) step();
        n_checks++;
        if (m_data !== 32'd0) $display("FAIL reset_m_data: got %h want 00000000", m_data);
        else n_pass++;
        sysReset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({rd_ptr, m_valid, empty, ptr_err} !== {11'd0, 1'b0, 1'b1, 1'b0})
                $display("FAIL reset_idle cyc%0d: rd_ptr=%0d valid=%b empty=%b err=%b want 0/0/1/0",
                         i, rd_ptr, m_valid, empty, ptr_err);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        mem[0]  = 32'hA5A5_0001;
        wr_ptr  = 11'd1;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || empty !== 1'b0)
            $display("FAIL single_pending: valid=%b empty=%b want 0/0", m_valid, empty);
        else n_pass++;
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001)
            $display("FAIL single_out: valid=%b data=%h want 1/a5a50001", m_valid, m_data);
        else n_pass++;
        n_checks++;
        if (rd_ptr !== 11'd1 || empty !== 1'b0)
            $display("FAIL single_ptr: rd_ptr=%0d empty=%b want 1/0", rd_ptr, empty);
        else n_pass++;
        step();
        n_checks++;
        if (m_valid !== 1'b0 || empty !== 1'b1)
            $display("FAIL single_drained: valid=%b empty=%b want 0/1", m_valid, empty);
        else n_pass++;
    endtask

    task automatic test_stream16();
        m_ready = 1'b1;
        preload(16, 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(i))
                $display("FAIL stream16 beat%0d: valid=%b data=%h want 1/%h", i, m_valid, m_data, 32'(i));
            else n_pass++;
        end
        step();
        n_checks++;
        if (m_valid !== 1'b0 || rd_ptr !== 11'd17)
            $display("FAIL stream16_end: valid=%b rd_ptr=%0d want 0/17", m_valid, rd_ptr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        preload(5, 32'd0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_ptr !== 11'd19 || m_valid !== 1'b1 || m_data !== 32'd0)
                $display("FAIL bp_stall cyc%0d: rd_ptr=%0d valid=%b data=%h want 19/1/0", i, rd_ptr, m_valid, m_data);
            else n_pass++;
            step();
        end
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(k))
                $display("FAIL bp_drain beat%0d: valid=%b data=%h want 1/%h", k, m_valid, m_data, 32'(k));
            else n_pass++;
            step();
        end
        n_checks++;
        if (m_valid !== 1'b0 || rd_ptr !== 11'd22)
            $display("FAIL bp_end: valid=%b rd_ptr=%0d want 0/22", m_valid, rd_ptr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        flush_to(11'd2046);
        n_checks++;
        if (rd_ptr !== 11'd2046 || m_valid !== 1'b0)
            $display("FAIL wrap_setup: rd_ptr=%0d valid=%b want 2046/0", rd_ptr, m_valid);
        else n_pass++;
        m_ready = 1'b1;
        preload(4, 32'hC0DE_0000);
        step();
        n_checks++;
        if (rd_ptr !== 11'd2047 || rd_addr !== 10'd1023)
            $display("FAIL wrap_addr: rd_ptr=%0d rd_addr=%0d want 2047/1023", rd_ptr, rd_addr);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'hC0DE_0000 + 32'(k))
                $display("FAIL wrap_beat%0d: valid=%b data=%h want 1/%h", k, m_valid, m_data, 32'hC0DE_0000 + 32'(k));
            else n_pass++;
            step();
        end
        n_checks++;
        if (m_valid !== 1'b0 || rd_ptr !== 11'd2 || rd_addr !== 10'd2)
            $display("FAIL wrap_end: valid=%b rd_ptr=%0d rd_addr=%0d want 0/2/2", m_valid, rd_ptr, rd_addr);
        else n_pass++;
        // Full RAM: equal low bits, opposite wrap bit.
        m_ready = 1'b0;
        wr_ptr  = 11'd1026;
        #1;
        n_checks++;
        if (empty !== 1'b0)
            $display("FAIL wrap_full_empty: got %b want 0", empty);
        else n_pass++;
        step();
        n_checks++;
        if (ptr_err !== 1'b0 || m_valid !== 1'b1 || rd_ptr !== 11'd3)
            $display("FAIL wrap_full_fetch: err=%b valid=%b rd_ptr=%0d want 0/1/3", ptr_err, m_valid, rd_ptr);
        else n_pass++;
        flush_to(11'd1026);
    endtask

    task automatic test_flush();
        logic [PW-1:0] exp_ptr;
        m_ready = 1'b0;
        preload(8, 32'h0000_0100);
        repeat (3) step();
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h100 + 32'(k))
                $display("FAIL flush_pop%0d: valid=%b data=%h want 1/%h", k, m_valid, m_data, 32'h100 + 32'(k));
            else n_pass++;
            step();
        end
        m_ready = 1'b0;
        flush   = 1'b1;
        exp_ptr = wr_ptr;
        step();
        flush = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || rd_ptr !== exp_ptr || empty !== 1'b1)
            $display("FAIL flush_result: valid=%b rd_ptr=%0d empty=%b want 0/%0d/1", m_valid, rd_ptr, empty, exp_ptr);
        else n_pass++;
        // A write landing in the flush cycle is discarded too.
        flush = 1'b1;
        preload(1, 32'hDEAD_BEEF);
        exp_ptr = wr_ptr;
        step();
        flush = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b0 || rd_ptr !== exp_ptr || empty !== 1'b1)
            $display("FAIL flush_same_cycle: valid=%b rd_ptr=%0d empty=%b want 0/%0d/1", m_valid, rd_ptr, empty, exp_ptr);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        m_ready = 1'b0;
        preload(3, 32'h0000_0055);
        step();
        step();
        #2;
        sysReset = 1'b0;
        wr_ptr   = '0;
        #1;
        n_checks++;
        if (rd_ptr !== 11'd0 || m_valid !== 1'b0 || m_data !== 32'd0)
            $display("FAIL async_reset: rd_ptr=%0d valid=%b data=%h want 0/0/0", rd_ptr, m_valid, m_data);
        else n_pass++;
        step();
        sysReset = 1'b1;
        step();
        n_checks++;
        if (empty !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL reset_release: empty=%b valid=%b want 1/0", empty, m_valid);
        else n_pass++;
    endtask

`ifdef CAXI4_RAM_RD_PTR_CHECK_EN
    task automatic test_ptr_check();
        m_ready = 1'b0;
        wr_ptr  = 11'd1025;
        step();
        n_checks++;
        if (ptr_err !== 1'b1 || rd_ptr !== 11'd0)
            $display("FAIL ptr_err_set: err=%b rd_ptr=%0d want 1/0", ptr_err, rd_ptr);
        else n_pass++;
        wr_ptr = 11'd3;
        repeat (3) step();
        n_checks++;
        if (ptr_err !== 1'b1 || rd_ptr !== 11'd0)
            $display("FAIL ptr_err_sticky: err=%b rd_ptr=%0d want 1/0", ptr_err, rd_ptr);
        else n_pass++;
        sysReset = 1'b0;
        wr_ptr   = '0;
        step();
        sysReset = 1'b1;
        step();
        n_checks++;
        if (ptr_err !== 1'b0)
            $display("FAIL ptr_err_clear: err=%b want 0", ptr_err);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_stream16();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_midstream();
`ifdef CAXI4_RAM_RD_PTR_CHECK_EN
        test_ptr_check();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/caxi4interconnect_ram_block_reader.md
Name: caxi4interconnect_ram_block_reader

Overview:
- Read-side controller for the interconnect's dual-port RAM buffers.
- Drives the RAM read address and captures the combinational RAM read data.
- Presents entries in order on a valid/ready stream with a 2-entry output buffer, sustaining 1 entry/cycle.
- Returns its read pointer to the writer side for the full computation; writer and reader share one clock.

Parameters:
- MEM_DEPTH, 1024, RAM entries; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 10, RAM address width; pointers are ADDR_WIDTH+1 bits (MSB = wrap bit).
- DATA_WIDTH, 32, entry width.

Ports:
- clk  in  1  Clock; all logic is on the rising edge.
- sysReset  in  1  Reset, asynchronous assertion, active-low.
- wr_ptr  in  ADDR_WIDTH+1  Writer's binary pointer (next slot to write), same clock.
- rd_ptr  out  ADDR_WIDTH+1  Reader's binary pointer (next slot to fetch).
- rd_addr  out  ADDR_WIDTH  RAM read address, equal to rd_ptr[ADDR_WIDTH-1:0] (combinational).
- ram_data  in  DATA_WIDTH  RAM data_out for rd_addr, valid in the same cycle.
- flush  in  1  Synchronous discard of all unread entries.
- m_valid  out  1  Output entry valid.
- m_ready  in  1  Consumer accepts the output entry.
- m_data  out  DATA_WIDTH  Output entry.
- empty  out  1  High when there are no RAM entries and no buffered entries.
- ptr_err  out  1  Sticky pointer error flag (see Optional Feature).

Behaviour:
- Reset (sysReset=0, async):
  - rd_ptr=0, buf_cnt=0, m_valid=0, m_data=0, skid register=0, empty=1, ptr_err=0.
- Definitions:
  - avail = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1); valid range 0..MEM_DEPTH.
  - pop = m_valid & m_ready.
  - fetch = (avail != 0) & ((buf_cnt < 2) | pop) & ~flush.
  - On fetch: ram_data is captured and rd_ptr increments by 1, wrapping naturally at 2^(ADDR_WIDTH+1).
- Buffer state machine (buf_cnt):
  - EMPTY(0): fetch -> ONE, data to out_reg.
  - ONE(1):
    - fetch & ~pop -> TWO, data to skid_reg.
    - fetch & pop -> ONE, data to out_reg.
    - ~fetch & pop -> EMPTY.
    - otherwise stay.
  - TWO(2):
    - pop & fetch -> TWO; skid_reg to out_reg, new data to skid_reg.
    - pop & ~fetch -> ONE; skid_reg to out_reg.
    - otherwise stay; no fetch and rd_ptr stalls.
- Outputs:
  - m_valid = (buf_cnt != 0), registered.
  - m_data = out_reg.
  - empty = (avail == 0) & (buf_cnt == 0).
- Latency: a RAM write that advances wr_ptr at edge N gives m_valid=1 after edge N+1, provided the buffer is empty.
- Throughput: 1 entry/cycle when m_ready is held high.
- Ordering: strict FIFO order; an entry is never duplicated or dropped, except by flush.
- Backpressure: m_data and m_valid hold stable while m_valid & ~m_ready.
- Flush: priority over fetch and pop. On the next edge rd_ptr <= wr_ptr and buf_cnt <= 0, so m_valid=0. A write arriving in the same cycle as flush is also discarded, because rd_ptr takes the wr_ptr value sampled that cycle.
- Reset mid-stream: all buffered data is lost and rd_ptr returns to 0. The writer must be reset together with this block.
- Wrap-around: pointers with equal low bits and differing MSB mean avail = MEM_DEPTH (RAM full). Equal pointers mean avail = 0.

Optional Feature:
- Macro: CAXI4_RAM_RD_PTR_CHECK_EN
- Defined:
  - ptr_err is set sticky (cleared only by reset) when avail > MEM_DEPTH, i.e. an illegal pointer relationship.
  - In simulation builds, an $error is reported on the same cycle.
  - While ptr_err=1, fetch is inhibited.
- Undefined: ptr_err is tied to 0 and no check logic is generated.

Decomposition:
- Shared package caxi4interconnect_ram_pkg holds:
  - buffer-state constants BUF_EMPTY=2'd0, BUF_ONE=2'd1, BUF_TWO=2'd2;
  - the pointer-difference function (avail computation), which the writer-side full logic reuses.
- One natural sub-module: caxi4interconnect_ram_rd_skid, holding the 2-entry out/skid buffer with the valid/ready state machine. Top level keeps the pointer, fetch and flush logic.

Test Plan:
- Reset released with wr_ptr=0 -> rd_ptr=0, m_valid=0, empty=1, ptr_err=0 for 10 cycles.
- Writer stores 0xA5A5_0001 at addr 0 and wr_ptr goes 0->1 at edge N; m_ready=1 -> m_valid=1 and m_data=0xA5A5_0001 after edge N+1; rd_ptr=1; empty=1 one cycle after the pop.
- Preload 16 entries (data = index), hold m_ready=1 -> 16 consecutive valid cycles with data 0..15 in order, no bubbles.
- Preload 5 entries, m_ready=0 -> buf_cnt reaches 2 and rd_ptr stops at 2; m_data stays 0. Raise m_ready -> data 0,1,2,3,4 out in order.
- Wrap: rd_ptr=wr_ptr=2046 (ADDR_WIDTH=10), write 4 entries -> wr_ptr=2 after wrapping. Drain 4 entries with correct data from addresses 1022, 1023, 0, 1; rd_ptr=2.
- Preload 8 entries, pop 3, assert flush for 1 cycle -> next cycle m_valid=0, rd_ptr=wr_ptr=8, empty=1. With CAXI4_RAM_RD_PTR_CHECK_EN defined, forcing wr_ptr-rd_ptr=1025 -> ptr_err=1 and it stays set until reset.
